// File: rtl/pc_next_unit_if.sv
// Fetch-side bundle between the decode/execute stage and the PC sequencer.
// The master drives the control inputs; the slave (pc_next_unit) drives pc and status.
interface pc_next_unit_if;
  logic [31:0] shifted_imm;
  logic [31:0] jalr_sum;
  logic        branch_taken;
  logic        jal;
  logic        jalr;
  logic        halt_req;
  logic        resume;
  logic        fetch_ready;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic [1:0]  state;
  logic        misaligned;
  logic [31:0] trap_epc;
  logic [31:0] instret;

  modport master (
    output shifted_imm, jalr_sum, branch_taken, jal, jalr, halt_req, resume,
           fetch_ready, stall,
    input  pc, pc_plus4, fetch_valid, state, misaligned, trap_epc, instret
  );

  modport slave (
    input  shifted_imm, jalr_sum, branch_taken, jal, jalr, halt_req, resume,
           fetch_ready, stall,
    output pc, pc_plus4, fetch_valid, state, misaligned, trap_epc, instret
  );
endinterface

// File: rtl/pc_next_unit.sv
// Program-counter sequencer: picks the next fetch address, traps on misaligned
// targets, parks in HALT on ECALL/EBREAK and counts retired instructions.
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input logic           clk,
  input logic           rst,
  pc_next_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    TRAP = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] epc_q, epc_d;
  logic        mis_q, mis_d;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      instret_q <= 32'd0;
      epc_q     <= 32'd0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      epc_q     <= epc_d;
      mis_q     <= mis_d;
    end
  end

  // Control inputs only matter on an advance; every other cycle holds state
  // unless a resume releases HALT/TRAP.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    epc_d     = epc_q;
    mis_d     = mis_q;
    pc_plus4  = pc_q + 32'd4;
    advance   = (state_q == RUN) && bus.fetch_ready && !bus.stall;

    if (bus.jalr)
      target = bus.jalr_sum & 32'hFFFF_FFFE;
    else if (bus.jal || bus.branch_taken)
      target = pc_q + bus.shifted_imm;
    else
      target = pc_plus4;

    if (advance) begin
      if (bus.halt_req) begin
        pc_d      = pc_plus4;
        instret_d = instret_q + 32'd1;
        state_d   = HALT;
      end else if (target[1]) begin
        pc_d    = TRAP_VECTOR;
        epc_d   = pc_q;
        mis_d   = 1'b1;
        state_d = TRAP;
      end else begin
        pc_d      = target;
        instret_d = instret_q + 32'd1;
      end
    end else if (state_q != RUN && bus.resume) begin
      state_d = RUN;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.state       = state_q;
  assign bus.misaligned  = mis_q;
  assign bus.trap_epc    = epc_q;
  assign bus.instret     = instret_q;

endmodule
